upsample_2x2: RTL and testbench
===============================

Name: upsample_2x2

Overview:
- Streaming 2x2 nearest-neighbour unpooling block, the inverse of the 2x2/stride-2 max-pool stage.
- Takes a raster-order pixel stream of IMG_WIDTH x IMG_HEIGHT and emits a raster-order stream of (2*IMG_WIDTH) x (2*IMG_HEIGHT).
- Each pixel is repeated horizontally; each row is replayed from an internal row buffer.
- Sits on the decoder path of the CNN datapath, feeding conv stages that expect full-resolution maps.

Parameters:
DATA_WIDTH, 8, pixel width in bits
IMG_WIDTH, 28, input pixels per row (>= 2)
IMG_HEIGHT, 28, input rows per frame (>= 1)

Ports:
Clk  input  1  clock, all logic on rising edge
Rst  input  1  asynchronous reset, active-low (Rst=0 resets)
valid_in  input  1  data_in carries a pixel
data_in  input  DATA_WIDTH  input pixel, raster order
ready_in  output  1  block accepts data_in this cycle
valid_out  output  1  data_out carries an output pixel
data_out  output  DATA_WIDTH  upsampled pixel, raster order
last_out  output  1  high with the final output pixel of a frame

Behaviour:
- Reset (Rst=0, async) forces the following; buffer contents are don't-care.
  - valid_out=0, data_out=0, last_out=0, ready_in=0 while in reset.
  - State=FILL, phase=0, col=0, rcol=0, row=0.
- Reset release: ready_in=1 on the first cycle after release. Reset mid-frame aborts the frame; no partial output follows.
- Accept = valid_in && ready_in. Upstream holds valid_in/data_in until accepted. valid_in while ready_in=0 is ignored.
- No downstream backpressure: the consumer must take every valid_out beat.
- FSM state FILL (emits output row 2r):
  - ready_in = (phase==0).
  - Accept at cycle t: write data_in to buffer[col]. data_out=data_in with valid_out=1 at t+1 and t+2 (two copies). phase=1 during t+1.
  - Latency: 1 cycle.
  - No accept in phase 0: valid_out=0 the next cycle (bubble); phase stays 0.
  - After the second copy of col=IMG_WIDTH-1: col=0, go to REPLAY.
- FSM state REPLAY (emits output row 2r+1):
  - ready_in=0.
  - Outputs buffer[rcol] twice per rcol, rcol 0..IMG_WIDTH-1.
  - valid_out=1 for exactly 2*IMG_WIDTH consecutive cycles, starting the cycle immediately after the last FILL copy, with no gap.
  - At end: rcol=0, row increments, return to FILL. ready_in=1 in the last REPLAY output cycle, so the next row's first pixel can follow with no bubble.
- Frame end:
  - last_out=1 together with the final REPLAY beat of row IMG_HEIGHT-1; 0 otherwise.
  - row wraps to 0; the next frame starts immediately.
- Throughput: at most 1 input per 2 cycles in FILL, 0 in REPLAY. Output is 4*IMG_WIDTH*IMG_HEIGHT beats per frame.
- Widths: col/rcol use $clog2(IMG_WIDTH) bits; row uses $clog2(IMG_HEIGHT) bits (min 1). No arithmetic on pixel data.
- Row buffer: IMG_WIDTH x DATA_WIDTH registers or single-port RAM. REPLAY reads must be prefetched so the no-gap rule holds.

Optional Feature:
- Macro: UPSAMPLE_ZERO_FILL_EN
- Defined: zero-insertion unpooling.
  - Only the top-left copy of each pixel carries data: FILL first copy = pixel, FILL second copy = 0.
  - Every REPLAY beat = 0.
  - Timing, valid_out, last_out and ready_in are identical to the default mode.
  - Row buffer writes may be omitted.
- Undefined: nearest-neighbour replication as described above.

Test Plan:
- IMG_WIDTH=4, IMG_HEIGHT=2, Rst low then high -> outputs 0 during reset; ready_in=1 on the first cycle after release.
- Continuous valid_in, row0=1,2,3,4 row1=5,6,7,8 -> data_out sequence:
  - 1,1,2,2,3,3,4,4 twice, then 5,5,6,6,7,7,8,8 twice.
  - 32 valid beats total; last_out=1 only on the 32nd beat (value 8).
- Pixel 3 delayed 3 cycles in row0 -> 3 bubble cycles (valid_out=0) after 2,2; REPLAY row still 8 gap-free beats 1,1,2,2,3,3,4,4.
- valid_in held high with data toggling while ready_in=0 (REPLAY and phase 1) -> no extra pixels captured; output sequence unchanged.
- Rst asserted after 5 output beats of frame 0, then released and a fresh frame (9..16) sent -> first output beat is 9; counters restart; last_out on beat 32 of the new frame.
- UPSAMPLE_ZERO_FILL_EN defined, same stimulus as scenario 2 -> 1,0,2,0,3,0,4,0, then 8 zeros, then 5,0,6,0,7,0,8,0, then 8 zeros; last_out on beat 32.

Source files
------------

// File: rtl/upsample_2x2.sv
// upsample_2x2: streaming 2x2 unpooling of a raster pixel stream (each pixel doubled, each row replayed).
// Define UPSAMPLE_ZERO_FILL_EN for zero-insertion unpooling instead of nearest-neighbour replication.
module upsample_2x2 #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  last_out
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(IMG_HEIGHT - 1);

  typedef enum logic {FILL, REPLAY} state_e;

  state_e                state_q, state_d;
  logic                  phase_q, phase_d;
  logic [COL_W-1:0]      col_q, col_d;
  logic [COL_W-1:0]      rcol_q, rcol_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_WIDTH-1:0] second_copy;
  logic [DATA_WIDTH-1:0] replay_data;
  logic                  accept;

  // Ready is gated by Rst so the block never advertises space while held in reset.
  assign ready_in  = Rst && (state_q == FILL) && !phase_q;
  assign accept    = valid_in && ready_in;
  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign last_out  = last_q;

`ifdef UPSAMPLE_ZERO_FILL_EN
  assign second_copy = '0;
  assign replay_data = '0;
`else
  logic [DATA_WIDTH-1:0] buf_q [IMG_WIDTH];

  always_ff @(posedge Clk) begin
    if (accept) buf_q[col_q] <= data_in;
  end

  // The buffer is a register file, so the replay read is available in the same cycle it is issued.
  assign second_copy = data_q;
  assign replay_data = buf_q[rcol_q];
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    col_d   = col_q;
    rcol_d  = rcol_q;
    row_d   = row_q;
    valid_d = 1'b0;
    last_d  = 1'b0;
    data_d  = data_q;
    unique case (state_q)
      FILL: begin
        if (!phase_q) begin
          if (accept) begin
            valid_d = 1'b1;
            data_d  = data_in;
            phase_d = 1'b1;
          end
        end else begin
          valid_d = 1'b1;
          data_d  = second_copy;
          phase_d = 1'b0;
          if (col_q == LAST_COL) begin
            col_d   = '0;
            state_d = REPLAY;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      REPLAY: begin
        valid_d = 1'b1;
        data_d  = replay_data;
        phase_d = !phase_q;
        if (phase_q) begin
          if (rcol_q == LAST_COL) begin
            rcol_d  = '0;
            state_d = FILL;
            last_d  = (row_q == LAST_ROW);
            row_d   = (row_q == LAST_ROW) ? '0 : row_q + 1'b1;
          end else begin
            rcol_d = rcol_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= FILL;
      phase_q <= 1'b0;
      col_q   <= '0;
      rcol_q  <= '0;
      row_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      col_q   <= col_d;
      rcol_q  <= rcol_d;
      row_q   <= row_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_upsample_2x2.sv
// tb_upsample_2x2: random-stimulus scoreboard bench for upsample_2x2 (4x2 input frames).
// Expected beats come from a plain-arithmetic picture model; a negedge monitor pops and compares.
module tb_upsample_2x2;

  localparam int DW    = 8;
  localparam int W     = 4;
  localparam int H     = 2;
  localparam int BEATS = 4 * W * H;

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          ready_in;
  logic          valid_out;
  logic [DW-1:0] data_out;
  logic          last_out;

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t         expQ[$];
  beat_t         expBeat;
  logic [DW-1:0] framePix [H][W];
  int            checks = 0;
  int            failures = 0;
  int            beatIdx = 0;
  int            beatsSeen = 0;
  int            oy, ox;
  logic          prevValid = 1'b0;
  logic          prevAccept = 1'b0;

  upsample_2x2 #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .Clk(Clk), .Rst(Rst), .valid_in(valid_in), .data_in(data_in),
    .ready_in(ready_in), .valid_out(valid_out), .data_out(data_out), .last_out(last_out)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s: timed out at %0t", name, $time);
  endtask

  // Output picture pixel (oy,ox) is input pixel (oy/2,ox/2), or zero off the top-left copy in zero-fill mode.
  task automatic pushFrame();
    beat_t b;
    for (int y = 0; y < 2 * H; y++) begin
      for (int x = 0; x < 2 * W; x++) begin
`ifdef UPSAMPLE_ZERO_FILL_EN
        b.data = (y % 2 == 0 && x % 2 == 0) ? framePix[y/2][x/2] : '0;
`else
        b.data = framePix[y/2][x/2];
`endif
        b.last = (y == 2 * H - 1) && (x == 2 * W - 1);
        expQ.push_back(b);
      end
    end
  endtask

  task automatic setFrameSeq(input int base);
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        framePix[r][c] = DW'(base + r * W + c);
  endtask

  // mode 0: back-to-back, mode 1: random gaps plus junk while not ready, mode 2: pixel (0,2) held back 3 cycles.
  task automatic applyStimulus(input int mode, input int abortAfter);
    int startBeats;
    startBeats = beatsSeen;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int gap;
        int guard;
        bit sent;
        gap   = (mode == 1) ? int'($urandom_range(0, 3)) : ((mode == 2 && r == 0 && c == 2) ? 3 : 0);
        guard = 0;
        sent  = 1'b0;
        while (!sent) begin
          if (abortAfter > 0 && (beatsSeen - startBeats) >= abortAfter) begin
            valid_in = 1'b0;
            return;
          end
          if (ready_in && gap == 0) begin
            valid_in = 1'b1;
            data_in  = framePix[r][c];
            sent     = 1'b1;
          end else begin
            valid_in = (!ready_in && mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            data_in  = DW'($urandom);
            if (ready_in) gap--;
          end
          @(posedge Clk);
          #1;
          guard++;
          if (guard > 200) begin
            reportTimeout("input_accept");
            valid_in = 1'b0;
            return;
          end
        end
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (expQ.size() != 0 && guard < 1000) begin
      @(posedge Clk);
      guard++;
    end
    checkOutput("drain_queue_empty", expQ.size(), 0);
    repeat (4) @(posedge Clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every beat and checks the beat's timing against its picture position.
  always @(negedge Clk) begin
    if (!Rst) begin
      checkOutput("reset_valid_out", valid_out, 0);
      checkOutput("reset_data_out", data_out, 0);
      checkOutput("reset_last_out", last_out, 0);
      checkOutput("reset_ready_in", ready_in, 0);
      beatIdx    = 0;
      prevValid  = 1'b0;
      prevAccept = 1'b0;
    end else begin
      if (valid_out) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_beat: got data %0h with empty scoreboard at %0t", data_out, $time);
        end else begin
          expBeat = expQ.pop_front();
          oy = beatIdx / (2 * W);
          ox = beatIdx % (2 * W);
          checkOutput("data_out", data_out, expBeat.data);
          checkOutput("last_out", last_out, expBeat.last);
          if (oy % 2 == 1 || ox % 2 == 1) checkOutput("gap_free", prevValid, 1);
          if (oy % 2 == 0 && ox % 2 == 0) begin
            checkOutput("latency_one", prevAccept, 1);
            checkOutput("ready_low_second_phase", ready_in, 0);
          end
          if (oy % 2 == 1 && ox == 2 * W - 1) checkOutput("ready_in_last_replay", ready_in, 1);
          beatIdx = (beatIdx + 1) % BEATS;
          beatsSeen++;
        end
      end else begin
        checkOutput("idle_last_out", last_out, 0);
      end
      prevValid  = valid_out;
      prevAccept = valid_in && ready_in;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #2 Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    #1 checkOutput("ready_after_release", ready_in, 1);
    @(posedge Clk);
    #1;

    $display("[TB] frame 1..8 back-to-back");
    setFrameSeq(1);
    pushFrame();
    applyStimulus(0, 0);
    waitDrain();

    $display("[TB] frame 1..8 with pixel 3 delayed");
    pushFrame();
    applyStimulus(2, 0);
    waitDrain();

    $display("[TB] random frames with gaps and junk");
    for (int f = 0; f < 6; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++)
          framePix[r][c] = DW'($urandom);
      pushFrame();
      applyStimulus(1, 0);
      waitDrain();
    end

    $display("[TB] two frames back-to-back");
    setFrameSeq(33);
    pushFrame();
    pushFrame();
    applyStimulus(0, 0);
    applyStimulus(0, 0);
    waitDrain();

    $display("[TB] reset mid-frame then fresh frame 9..16");
    setFrameSeq(1);
    pushFrame();
    applyStimulus(0, 5);
    valid_in = 1'b0;
    Rst = 1'b0;
    expQ.delete();
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b1;
    #1 checkOutput("ready_after_mid_reset", ready_in, 1);
    @(posedge Clk);
    #1;
    setFrameSeq(9);
    pushFrame();
    applyStimulus(0, 0);
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
